step_pulse_gen: RTL and testbench

//   Output side of the stepper interface: the transmit counterpart of the input chatter filter.

---
 rtl/step_pulse_gen_if.sv | 20 ++
 rtl/step_pulse_gen.sv | 159 +++++++++++++++
 tb/tb_step_pulse_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/step_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_gen_if
// Brief    : Move-command handshake channel into the STEP/DIR pulse generator.
// Revision : 1.0
// ============================================================================
interface step_pulse_gen_if #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
);
  logic             CMD_VALID;
  logic             CMD_READY;
  logic             CMD_DIR;
  logic [CNT_W-1:0] CMD_STEPS;
  logic [PER_W-1:0] CMD_PERIOD;

  modport master (output CMD_VALID, CMD_DIR, CMD_STEPS, CMD_PERIOD, input CMD_READY);
  modport slave  (input CMD_VALID, CMD_DIR, CMD_STEPS, CMD_PERIOD, output CMD_READY);
endinterface
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : step_pulse_gen
// Brief    : Turns a commanded move into timed STEP/DIR pulses and tracks position.
// Revision : 1.0
// ============================================================================
module step_pulse_gen #(
  parameter int CNT_W           = 16,
  parameter int PER_W           = 16,
  parameter int POS_W           = 32,
  parameter int HIGH_TICKS      = 4,
  parameter int DIR_SETUP_TICKS = 2
) (
  input  wire logic             CLK,
  input  wire logic             RST_N,
  input  wire logic             CE,
  input  wire logic             ABORT,
  step_pulse_gen_if.slave       cmd,
  output logic                  STEP,
  output logic                  DIR,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [POS_W-1:0]      POS
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LOW   = 2'd3
  } state_t;

  localparam logic [PER_W-1:0] c_min_period = PER_W'(HIGH_TICKS + 1);
  localparam logic [PER_W-1:0] c_high_last  = PER_W'(HIGH_TICKS - 1);
  localparam logic [PER_W-1:0] c_setup_last =
    PER_W'((DIR_SETUP_TICKS > 0) ? DIR_SETUP_TICKS - 1 : 0);
  localparam bit c_no_setup = (DIR_SETUP_TICKS == 0);

  state_t           r_state;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_low_last;
  logic [CNT_W-1:0] r_left;
  logic             r_abort_pend;
  logic             r_ready_en;

  logic             w_accept;
  logic [PER_W-1:0] w_period_eff;
  logic [PER_W-1:0] w_low_last;

  function automatic logic [POS_W-1:0] f_pos_next(input logic [POS_W-1:0] p, input logic d);
    return d ? (p + POS_W'(1)) : (p - POS_W'(1));
  endfunction

  assign cmd.CMD_READY = (r_state == S_IDLE) & RST_N & r_ready_en & ~ABORT;
  assign w_accept      = cmd.CMD_VALID & cmd.CMD_READY;
  assign w_period_eff  = (cmd.CMD_PERIOD < c_min_period) ? c_min_period : cmd.CMD_PERIOD;
  // Last LOW tick index: P - HIGH_TICKS ticks in LOW, counted from zero.
  assign w_low_last    = w_period_eff - c_min_period;
  assign BUSY          = (r_state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_low_last   <= '0;
      r_left       <= '0;
      r_abort_pend <= 1'b0;
      r_ready_en   <= 1'b0;
      STEP         <= 1'b0;
      DIR          <= 1'b0;
      DONE         <= 1'b0;
      POS          <= '0;
    end else begin
      r_ready_en <= 1'b1;
      DONE       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt        <= '0;
          r_abort_pend <= 1'b0;
          if (w_accept) begin
            r_low_last <= w_low_last;
            if (cmd.CMD_STEPS == '0) begin
              DONE <= 1'b1;
            end else if ((cmd.CMD_DIR == DIR) || c_no_setup) begin
              r_state <= S_HIGH;
              STEP    <= 1'b1;
              DIR     <= cmd.CMD_DIR;
              POS     <= f_pos_next(POS, cmd.CMD_DIR);
              r_left  <= cmd.CMD_STEPS - CNT_W'(1);
            end else begin
              r_state <= S_SETUP;
              DIR     <= cmd.CMD_DIR;
              r_left  <= cmd.CMD_STEPS;
            end
          end
        end
        S_SETUP: begin
          if (ABORT) begin
            r_state <= S_IDLE;
            DONE    <= 1'b1;
          end else if (CE) begin
            if (r_cnt == c_setup_last) begin
              r_state <= S_HIGH;
              r_cnt   <= '0;
              STEP    <= 1'b1;
              POS     <= f_pos_next(POS, DIR);
              r_left  <= r_left - CNT_W'(1);
            end else begin
              r_cnt <= r_cnt + PER_W'(1);
            end
          end
        end
        S_HIGH: begin
          // An abort during the high phase is remembered so the pulse is never cut short.
          r_abort_pend <= r_abort_pend | ABORT;
          if (CE) begin
            if (r_cnt == c_high_last) begin
              r_cnt <= '0;
              STEP  <= 1'b0;
              if (r_abort_pend || ABORT) begin
                r_state <= S_IDLE;
                DONE    <= 1'b1;
              end else begin
                r_state <= S_LOW;
              end
            end else begin
              r_cnt <= r_cnt + PER_W'(1);
            end
          end
        end
        S_LOW: begin
          if (ABORT) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            DONE    <= 1'b1;
          end else if (CE) begin
            if (r_cnt == r_low_last) begin
              r_cnt <= '0;
              if (r_left == '0) begin
                r_state <= S_IDLE;
                DONE    <= 1'b1;
              end else begin
                r_state <= S_HIGH;
                STEP    <= 1'b1;
                POS     <= f_pos_next(POS, DIR);
                r_left  <= r_left - CNT_W'(1);
              end
            end else begin
              r_cnt <= r_cnt + PER_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_step_pulse_gen
// Brief    : Directed, table-driven bench for the STEP/DIR pulse generator.
// Revision : 1.0
// ============================================================================
module tb_step_pulse_gen;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic        ABORT;
  logic        STEP;
  logic        DIR;
  logic        BUSY;
  logic        DONE;
  logic [31:0] POS;

  int n_checks = 0;
  int n_fail   = 0;

  step_pulse_gen_if #(.CNT_W(16), .PER_W(16)) cmd_if ();

  step_pulse_gen #(
    .CNT_W(16), .PER_W(16), .POS_W(32), .HIGH_TICKS(4), .DIR_SETUP_TICKS(2)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .ABORT (ABORT),
    .cmd   (cmd_if),
    .STEP  (STEP),
    .DIR   (DIR),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .POS   (POS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        dir;
    int          steps;
    int          period;
    int          ce_div;      // CE high on every ce_div-th edge after accept
    int          abort_n;     // edge index (from accept) that samples ABORT=1, 0 = none
    int          exp_first;   // edge index of first STEP rise
    int          exp_gap;     // edges between consecutive rises
    int          exp_high;    // STEP high width in CLK
    int          exp_pulses;
    int          exp_done;    // DONE edge minus last rise, or absolute when no pulses
    logic [31:0] exp_pos;
    logic        exp_dir;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   rises[$];
    int   falls[$];
    int   done_n;
    int   done_cnt;
    int   n;
    logic prev_step;
    chk($sformatf("v%0d ready_before", idx), longint'(cmd_if.CMD_READY), 1);
    cmd_if.CMD_DIR    = v.dir;
    cmd_if.CMD_STEPS  = 16'(v.steps);
    cmd_if.CMD_PERIOD = 16'(v.period);
    cmd_if.CMD_VALID  = 1'b1;
    CE        = 1'b1;
    ABORT     = 1'b0;
    prev_step = STEP;
    done_n    = -1;
    done_cnt  = 0;
    n         = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (n == 0) begin
        cmd_if.CMD_VALID = 1'b0;
        chk($sformatf("v%0d dir_after_accept", idx), longint'(DIR), longint'(v.exp_dir));
        chk($sformatf("v%0d busy_after_accept", idx), longint'(BUSY), (v.exp_pulses > 0) ? 1 : 0);
      end
      if (STEP && !prev_step) rises.push_back(n);
      if (!STEP && prev_step) falls.push_back(n);
      prev_step = STEP;
      if (DONE) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      ABORT = (v.abort_n != 0) && (n + 1 == v.abort_n);
      CE    = (v.ce_div <= 1) ? 1'b1 : (((n + 1) % v.ce_div) == 0);
      if (done_n >= 0 && n >= done_n + 2) break;
      if (n >= 400) begin
        chk($sformatf("v%0d timeout_waiting_done", idx), 1, 0);
        break;
      end
      n++;
    end
    CE    = 1'b1;
    ABORT = 1'b0;

    chk($sformatf("v%0d pulses", idx), rises.size(), v.exp_pulses);
    if (rises.size() > 0)
      chk($sformatf("v%0d first_rise", idx), rises[0], v.exp_first);
    for (int i = 1; i < rises.size(); i++)
      chk($sformatf("v%0d rise_gap%0d", idx, i), rises[i] - rises[i-1], v.exp_gap);
    chk($sformatf("v%0d falls", idx), falls.size(), rises.size());
    for (int i = 0; i < falls.size() && i < rises.size(); i++)
      chk($sformatf("v%0d high%0d", idx, i), falls[i] - rises[i], v.exp_high);
    chk($sformatf("v%0d done_count", idx), done_cnt, 1);
    if (v.exp_pulses == 0)
      chk($sformatf("v%0d done_delay", idx), done_n, v.exp_done);
    else if (rises.size() > 0)
      chk($sformatf("v%0d done_after_last_rise", idx), done_n - rises[rises.size()-1], v.exp_done);
    chk($sformatf("v%0d pos", idx), longint'(POS), longint'(v.exp_pos));
    chk($sformatf("v%0d dir_final", idx), longint'(DIR), longint'(v.exp_dir));
    chk($sformatf("v%0d busy_final", idx), longint'(BUSY), 0);
    chk($sformatf("v%0d step_final", idx), longint'(STEP), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //           dir  steps per ce abort first gap high pulses done  pos            dir
    vecs[0] = '{1'b0,  3, 10, 1,  0,    0,  10,  4,   3,    10, 32'hFFFF_FFFD, 1'b0};
    vecs[1] = '{1'b1,  2,  8, 1,  0,    2,   8,  4,   2,     8, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{1'b1,  2,  2, 1,  0,    0,   5,  4,   2,     5, 32'h0000_0001, 1'b1};
    vecs[3] = '{1'b0,  0,  7, 1,  0,    0,   0,  4,   0,     0, 32'h0000_0001, 1'b1};
    vecs[4] = '{1'b0, 10, 10, 1, 14,    2,  10,  4,   2,     4, 32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{1'b1,  1,  6, 4,  0,    8,   0, 16,   1,    24, 32'h0000_0000, 1'b1};

    RST_N             = 1'b0;
    CE                = 1'b1;
    ABORT             = 1'b0;
    cmd_if.CMD_VALID  = 1'b1;
    cmd_if.CMD_DIR    = 1'b1;
    cmd_if.CMD_STEPS  = 16'd5;
    cmd_if.CMD_PERIOD = 16'd10;

    // Reset held with a pending command: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      chk("rst ready", longint'(cmd_if.CMD_READY), 0);
      chk("rst step", longint'(STEP), 0);
      chk("rst dir", longint'(DIR), 0);
      chk("rst pos", longint'(POS), 0);
      chk("rst busy", longint'(BUSY), 0);
    end
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    chk("post_rst ready", longint'(cmd_if.CMD_READY), 1);
    chk("post_rst busy", longint'(BUSY), 0);
    chk("post_rst step", longint'(STEP), 0);
    cmd_if.CMD_VALID = 1'b0;

    // ABORT while idle only blocks acceptance.
    ABORT            = 1'b1;
    cmd_if.CMD_VALID = 1'b1;
    #1;
    chk("idle_abort ready", longint'(cmd_if.CMD_READY), 0);
    @(posedge CLK);
    #1;
    chk("idle_abort busy", longint'(BUSY), 0);
    chk("idle_abort done", longint'(DONE), 0);
    chk("idle_abort pos", longint'(POS), 0);
    ABORT            = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    #1;
    chk("idle_abort ready_back", longint'(cmd_if.CMD_READY), 1);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
